// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with forwarding, scoreboard and clear sweep
module regfile_mp #(
  parameter int WORDLENGTH         = 32,
  parameter int REG_FILE_SIZE      = 32,
  parameter int REG_ADDRESS_LENGTH = 5,
  parameter int NUM_RD             = 2,
  parameter bit BYPASS             = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear_req,
  output logic                                 ready,
  input  logic [NUM_RD*REG_ADDRESS_LENGTH-1:0] rd_addr,
  output logic [NUM_RD*WORDLENGTH-1:0]         rd_data,
  output logic [NUM_RD-1:0]                    rd_busy,
  input  logic                                 wr0_en,
  input  logic [REG_ADDRESS_LENGTH-1:0]        wr0_addr,
  input  logic [WORDLENGTH-1:0]                wr0_data,
  input  logic                                 wr1_en,
  input  logic [REG_ADDRESS_LENGTH-1:0]        wr1_addr,
  input  logic [WORDLENGTH-1:0]                wr1_data,
  input  logic                                 rsv_en,
  input  logic [REG_ADDRESS_LENGTH-1:0]        rsv_addr,
  output logic                                 err_addr
);
  localparam int AW = REG_ADDRESS_LENGTH;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  state_t                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic [REG_FILE_SIZE-1:0] pend_q, pend_d;
  logic [WORDLENGTH-1:0]   mem_q [REG_FILE_SIZE];
  logic                    err_q, err_d;
  logic                    acc, wr0_ok, wr1_ok, rsv_ok;
  logic [NUM_RD-1:0]       rd_bad;

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < REG_FILE_SIZE;
  endfunction

  function automatic logic usable(input logic [AW-1:0] a);
    return in_range(a) && a != '0;
  endfunction

  // Accesses only take effect in IDLE when no clear is being requested; r0 is never a target.
  assign acc    = state_q == IDLE && !clear_req;
  assign wr0_ok = acc && wr0_en && usable(wr0_addr);
  assign wr1_ok = acc && wr1_en && usable(wr1_addr);
  assign rsv_ok = acc && rsv_en && usable(rsv_addr);
  assign ready  = state_q == IDLE;
  assign err_addr = err_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          ok, h0, h1;
    assign a         = rd_addr[k*AW +: AW];
    assign ok        = state_q == IDLE && usable(a);
    assign h0        = BYPASS && wr0_ok && wr0_addr == a;
    assign h1        = BYPASS && wr1_ok && wr1_addr == a;
    assign rd_bad[k] = !in_range(a);
    assign rd_data[k*WORDLENGTH +: WORDLENGTH] = !ok ? '0 : h1 ? wr1_data : h0 ? wr0_data : mem_q[a];
    assign rd_busy[k] = ok && ((h0 || h1) ? (rsv_ok && rsv_addr == a) : pend_q[a]);
  end

  // Sweep FSM: clear_req in IDLE starts a sweep at index 0, last index returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (clear_req) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    end else if (int'(cnt_q) == REG_FILE_SIZE - 1) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Scoreboard next state: writes clear, a same-cycle reservation wins; the sweep clears one bit per cycle.
  always_comb begin
    pend_d = pend_q;
    if (state_q == CLEAR) begin
      pend_d[cnt_q] = 1'b0;
    end else begin
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        if ((wr0_ok && int'(wr0_addr) == i) || (wr1_ok && int'(wr1_addr) == i)) pend_d[i] = 1'b0;
        if (rsv_ok && int'(rsv_addr) == i) pend_d[i] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;
  end

  // Address error flag covers enabled writes/reservations and every read port.
  always_comb begin
    err_d = (wr0_en && !in_range(wr0_addr)) || (wr1_en && !in_range(wr1_addr)) ||
            (rsv_en && !in_range(rsv_addr)) || (|rd_bad);
  end

  // Control state with asynchronous reset that restarts the sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset; it is zeroed by the sweep, and wr1 is applied last so it wins.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (wr0_ok) mem_q[wr0_addr] <= wr0_data;
      if (wr1_ok) mem_q[wr1_addr] <= wr1_data;
    end
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- WORDLENGTH, 32, data width in bits.
- REG_FILE_SIZE, 32, number of registers.
- REG_ADDRESS_LENGTH, 5, address width; SHALL satisfy 2^REG_ADDRESS_LENGTH >= REG_FILE_SIZE.
- NUM_RD, 2, read port count (1..4).
- BYPASS, 1, 1 = write-to-read forwarding in the same cycle.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on the rising edge.
- reset, in, 1, asynchronous, active-low.
- clear_req, in, 1, synchronous request to zero all registers.
- ready, out, 1, 1 = file usable; 0 = clear sweep in progress.
- rd_addr, in, NUM_RD*REG_ADDRESS_LENGTH, packed read addresses; port k at slice k.
- rd_data, out, NUM_RD*WORDLENGTH, packed combinational read data.
- rd_busy, out, NUM_RD, scoreboard pending bit per read port.
- wr0_en / wr0_addr / wr0_data, in, 1 / REG_ADDRESS_LENGTH / WORDLENGTH, write port 0.
- wr1_en / wr1_addr / wr1_data, in, 1 / REG_ADDRESS_LENGTH / WORDLENGTH, write port 1.
- rsv_en / rsv_addr, in, 1 / REG_ADDRESS_LENGTH, marks a destination register pending.
- err_addr, out, 1, registered; pulses 1 for one cycle after any enabled access to an address >= REG_FILE_SIZE.

Function
REQ-003 Register 0 SHALL read as 0 at all times; writes and reservations to it SHALL be ignored.
REQ-004 A write with enable and a valid address SHALL update its register on the rising edge.
REQ-005 When both write ports target the same address in one cycle, wr1 SHALL win.
REQ-006 With BYPASS=1, a read of an address being written this cycle SHALL return the incoming data (wr1 before wr0); with BYPASS=0 it SHALL return the old value.
REQ-007 A read of an invalid address SHALL return 0.
REQ-008 Scoreboard: a per-register pending bit SHALL be set by rsv_en and cleared by any write to that register.
REQ-009 When rsv_en and a write target the same register in one cycle, the pending bit SHALL end set.
REQ-010 rd_busy[k] SHALL equal the pending bit of rd_addr[k].
REQ-011 With BYPASS=1, rd_busy[k] SHALL be 0 when that register is being written this cycle and is not re-reserved.
REQ-012 FSM states SHALL be IDLE and CLEAR.
- IDLE to CLEAR: on clear_req.
- CLEAR: a sweep counter zeroes one register and its pending bit per cycle, index 0 up to REG_FILE_SIZE-1.
- CLEAR to IDLE: after the last index.
- A clear takes exactly REG_FILE_SIZE cycles.
REQ-013 While in CLEAR:
- ready SHALL be 0.
- rd_data and rd_busy SHALL read 0.
- writes and reservations SHALL be ignored.
- clear_req SHALL be ignored.
REQ-014 ready SHALL rise on the edge that completes the sweep.
REQ-015 clear_req asserted in IDLE SHALL enter CLEAR on the next edge, and that cycle's writes SHALL be discarded.
REQ-016 err_addr SHALL flag an invalid address on an enabled write, an enabled reservation, or any read port whose address is invalid.

Reset
REQ-017 reset low SHALL immediately, without clk, force:
- state = CLEAR,
- sweep counter = 0,
- all pending bits = 0,
- ready = 0,
- err_addr = 0.
REQ-018 On reset release, the sweep SHALL run and ready SHALL rise exactly REG_FILE_SIZE rising edges later; the storage array has no reset net.
REQ-019 Reset asserted mid-sweep SHALL restart the sweep from index 0.

Verification
REQ-020 Reset release, defaults: count edges -> ready rises after 32 edges; all reads 0; rd_busy = 0.
REQ-021 wr0 r5 = 0xAAAA0000 and wr1 r5 = 0x5555FFFF in the same cycle -> next cycle r5 = 0x5555FFFF; with BYPASS=1, a same-cycle read of r5 returns 0x5555FFFF.
REQ-022 Write r0 = 0xFFFFFFFF -> r0 reads 0; a read of address 0 is never busy.
REQ-023 Scoreboard sequence:
- rsv r7 -> rd_busy for r7 = 1.
- wr0 r7 = 0x12 -> busy for r7 = 0 from that cycle with BYPASS=1.
- rsv r7 and wr r7 in the same cycle -> busy for r7 remains 1.
REQ-024 clear_req with data in r1..r31 -> ready = 0 for 32 cycles and writes during the sweep are dropped; afterwards all registers read 0.
REQ-025 Boundary cases:
- REG_FILE_SIZE = 24: a write to address 30 -> err_addr = 1 next cycle and no register changes.
- reset pulsed at sweep index 10 -> sweep restarts from 0.
